// File: rtl/rtc_pkg.sv
// Shared constants, scan address table and sequencer state encoding for the
// RTC scan controller.
package rtc_pkg;

  localparam int unsigned SCAN_LEN = 11;
  localparam int unsigned IDX_W    = 4;

  localparam logic [7:0] TIME_BASE  = 8'h21;
  localparam logic [7:0] TIMER_BASE = 8'h41;
  localparam logic [7:0] LATCH_CMD  = 8'hF0;

  // Entry 0 sits in the low byte: 0x21..0x28 then 0x41..0x43.
  localparam logic [SCAN_LEN-1:0][7:0] SCAN_TABLE = {
    TIMER_BASE + 8'h02, TIMER_BASE + 8'h01, TIMER_BASE,
    TIME_BASE + 8'h07, TIME_BASE + 8'h06, TIME_BASE + 8'h05, TIME_BASE + 8'h04,
    TIME_BASE + 8'h03, TIME_BASE + 8'h02, TIME_BASE + 8'h01, TIME_BASE
  };

  typedef enum logic [3:0] {
    StIdle,
    StLatch,
    StLatchWait,
    StRd,
    StRdWait,
    StPush,
    StNext,
    StWr,
    StWrWait
  } rtc_state_e;

  function automatic logic [7:0] scan_addr(input logic [IDX_W-1:0] idx);
    return (idx < IDX_W'(SCAN_LEN)) ? SCAN_TABLE[idx] : 8'h00;
  endfunction

endpackage

// File: rtl/rtc_timer_cnt.sv
// Loadable up-counter that saturates at a terminal count and flags it.
module rtc_timer_cnt #(
  parameter int unsigned      Width    = 8,
  parameter logic [Width-1:0] Terminal = '1,
  parameter logic [Width-1:0] ResetVal = '0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load_i,
  input  logic [Width-1:0] load_val_i,
  input  logic             en_i,
  output logic             tc_o
);

  logic [Width-1:0] cnt_q, cnt_d;

  assign tc_o = (cnt_q == Terminal);

  always_comb begin
    cnt_d = cnt_q;
    if (load_i) begin
      cnt_d = load_val_i;
    end else if (en_i && !tc_o) begin
      cnt_d = cnt_q + Width'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q <= ResetVal;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/rtc_scan_controller.sv
// Periodic RTC register scanner with user-write arbitration onto the shared
// RTC bus; read results are presented to the display register bank.
module rtc_scan_controller
  import rtc_pkg::*;
#(
  parameter int unsigned REFRESH_CYCLES = 100000,
  parameter int unsigned TIMEOUT_CYCLES = 1024,
  parameter logic [7:0]  LATCH_ADDR     = LATCH_CMD
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       wr_req,
  input  logic [7:0] wr_addr,
  input  logic [7:0] wr_data,
  output logic       wr_ack,
  output logic       bus_start,
  output logic       bus_rw,
  output logic [7:0] bus_addr,
  output logic [7:0] bus_wdata,
  input  logic       bus_done,
  input  logic [7:0] bus_rdata,
  output logic [7:0] address,
  output logic [7:0] data_vga,
  output logic       AoD,
  output logic       scan_busy,
  output logic       frame_done,
  output logic       bus_err
);

  localparam int unsigned RefW = $clog2(REFRESH_CYCLES + 1);
  localparam int unsigned ToW  = $clog2(TIMEOUT_CYCLES + 1);

  rtc_state_e       state_q, state_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic [7:0]       rdata_q, rdata_d;
  logic             scan_q, scan_d;
  logic             err_q, err_d;
  logic             ack_q, ack_d;

  logic             ref_load, ref_en, ref_tc;
  logic             to_load, to_en, to_tc;
  logic             last_idx;
  logic             wr_pending;
  logic [7:0]       cur_addr;

  assign cur_addr   = scan_addr(idx_q);
  assign last_idx   = (idx_q == IDX_W'(SCAN_LEN - 1));
  // wr_req is still high during the wr_ack cycle; that request is already served.
  assign wr_pending = wr_req && !ack_q;
  assign ref_en     = (state_q == StIdle);

  assign wr_ack    = ack_q;
  assign scan_busy = scan_q;
  assign bus_err   = err_q;

  // Preloaded to terminal so the first scan begins right out of reset.
  rtc_timer_cnt #(
    .Width   (RefW),
    .Terminal(RefW'(REFRESH_CYCLES - 1)),
    .ResetVal(RefW'(REFRESH_CYCLES - 1))
  ) u_refresh_cnt (
    .clk       (clk),
    .reset     (reset),
    .load_i    (ref_load),
    .load_val_i('0),
    .en_i      (ref_en),
    .tc_o      (ref_tc)
  );

  rtc_timer_cnt #(
    .Width   (ToW),
    .Terminal(ToW'(TIMEOUT_CYCLES - 1)),
    .ResetVal('0)
  ) u_timeout_cnt (
    .clk       (clk),
    .reset     (reset),
    .load_i    (to_load),
    .load_val_i('0),
    .en_i      (to_en),
    .tc_o      (to_tc)
  );

  always_comb begin
    state_d    = state_q;
    idx_d      = idx_q;
    rdata_d    = rdata_q;
    scan_d     = scan_q;
    err_d      = err_q;
    ack_d      = 1'b0;
    ref_load   = 1'b0;
    to_load    = 1'b0;
    to_en      = 1'b0;
    bus_start  = 1'b0;
    bus_rw     = 1'b1;
    bus_addr   = 8'h00;
    bus_wdata  = 8'h00;
    address    = 8'h00;
    data_vga   = 8'h00;
    AoD        = 1'b1;
    frame_done = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (wr_pending) begin
          state_d = StWr;
        end else if (ref_tc) begin
          state_d  = StLatch;
          ref_load = 1'b1;
          err_d    = 1'b0;
          scan_d   = 1'b1;
        end
      end
      StLatch, StLatchWait: begin
        bus_rw    = 1'b0;
        bus_addr  = LATCH_ADDR;
        bus_wdata = LATCH_ADDR;
        if (state_q == StLatch) begin
          bus_start = 1'b1;
          to_load   = 1'b1;
          state_d   = StLatchWait;
        end else begin
          to_en = 1'b1;
          if (bus_done) begin
            state_d = StRd;
          end else if (to_tc) begin
            err_d   = 1'b1;
            state_d = StRd;
          end
        end
      end
      StRd: begin
        bus_start = 1'b1;
        bus_addr  = cur_addr;
        to_load   = 1'b1;
        state_d   = StRdWait;
      end
      StRdWait: begin
        bus_addr = cur_addr;
        to_en    = 1'b1;
        if (bus_done) begin
          rdata_d = bus_rdata;
          state_d = StPush;
        end else if (to_tc) begin
          err_d   = 1'b1;
          state_d = StNext;
        end
      end
      StPush: begin
        address  = cur_addr;
        data_vga = rdata_q;
        AoD      = 1'b0;
        if (last_idx) scan_d = 1'b0;
        state_d = StNext;
      end
      StNext: begin
        if (last_idx) begin
          frame_done = 1'b1;
          idx_d      = '0;
          scan_d     = 1'b0;
          state_d    = StIdle;
        end else begin
          idx_d   = idx_q + IDX_W'(1);
          state_d = wr_pending ? StWr : StRd;
        end
      end
      StWr, StWrWait: begin
        bus_rw    = 1'b0;
        bus_addr  = wr_addr;
        bus_wdata = wr_data;
        if (state_q == StWr) begin
          bus_start = 1'b1;
          to_load   = 1'b1;
          state_d   = StWrWait;
        end else begin
          to_en = 1'b1;
          if (bus_done || to_tc) begin
            // A timed-out write still acks so the requester is released.
            ack_d   = 1'b1;
            err_d   = err_q | !bus_done;
            state_d = scan_q ? StRd : StIdle;
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= StIdle;
      idx_q   <= '0;
      rdata_q <= 8'h00;
      scan_q  <= 1'b0;
      err_q   <= 1'b0;
      ack_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      rdata_q <= rdata_d;
      scan_q  <= scan_d;
      err_q   <= err_d;
      ack_q   <= ack_d;
    end
  end

endmodule

// File: tb/tb_rtc_scan_controller.sv
// Directed bench for rtc_scan_controller with a 3-cycle transceiver model.
module tb_rtc_scan_controller;

  typedef struct {
    logic       rw;
    logic [7:0] addr;
    logic [7:0] wdata;
    logic       push;
  } vec_t;

  typedef struct {
    logic       rw;
    logic [7:0] addr;
    logic [7:0] wdata;
    logic       err;
    int         cyc;
  } txn_t;

  typedef struct {
    logic [7:0] addr;
    logic [7:0] data;
    int         cyc;
  } push_t;

  logic       clk = 1'b0;
  logic       reset;
  logic       wr_req;
  logic [7:0] wr_addr, wr_data;
  logic       wr_ack, bus_start, bus_rw, bus_done;
  logic [7:0] bus_addr, bus_wdata, bus_rdata, address, data_vga;
  logic       AoD, scan_busy, frame_done, bus_err;
  logic       mdl_done, spur;
  logic [7:0] drop_addr;

  int         n_pass = 0;
  int         n_total = 0;
  int         cyc = 0;
  int         frames = 0;
  int         acks = 0;
  int         err_rise = -1;
  int         fd_q[$];
  txn_t       txn[$];
  push_t      pushes[$];
  vec_t       ev[$];
  logic [7:0] scan_tbl [11];

  localparam logic [38:0] RST_VEC = {1'b0, 1'b1, 8'h00, 8'h00, 8'h00, 8'h00,
                                     1'b1, 1'b0, 1'b0, 1'b0, 1'b0};

  assign bus_done = mdl_done | spur;

  always #5 clk = ~clk;

  rtc_scan_controller #(
    .REFRESH_CYCLES(64),
    .TIMEOUT_CYCLES(32),
    .LATCH_ADDR    (8'hF0)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .wr_req    (wr_req),
    .wr_addr   (wr_addr),
    .wr_data   (wr_data),
    .wr_ack    (wr_ack),
    .bus_start (bus_start),
    .bus_rw    (bus_rw),
    .bus_addr  (bus_addr),
    .bus_wdata (bus_wdata),
    .bus_done  (bus_done),
    .bus_rdata (bus_rdata),
    .address   (address),
    .data_vga  (data_vga),
    .AoD       (AoD),
    .scan_busy (scan_busy),
    .frame_done(frame_done),
    .bus_err   (bus_err)
  );

  // Transceiver: bus_done three cycles after bus_start, rdata = addr ^ 0x5A.
  initial begin
    int         dly;
    logic [7:0] a;
    dly       = 0;
    a         = 8'h00;
    mdl_done  = 1'b0;
    bus_rdata = 8'h00;
    forever begin
      @(negedge clk);
      #1;
      mdl_done = 1'b0;
      if (reset) begin
        dly = 0;
      end else begin
        if (dly > 0) begin
          dly--;
          if (dly == 0) begin
            mdl_done  = 1'b1;
            bus_rdata = a ^ 8'h5A;
          end
        end
        if (bus_start && !(bus_rw && bus_addr == drop_addr)) begin
          dly = 3;
          a   = bus_addr;
        end
      end
    end
  end

  // Event log, sampled just after each rising edge.
  initial begin
    logic err_prev;
    err_prev = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      cyc++;
      if (!reset) begin
        if (bus_start) txn.push_back('{bus_rw, bus_addr, bus_wdata, bus_err, cyc});
        if (!AoD) pushes.push_back('{address, data_vga, cyc});
        if (frame_done) begin
          frames++;
          fd_q.push_back(cyc);
        end
        if (wr_ack) acks++;
        if (bus_err && !err_prev) err_rise = cyc;
      end
      err_prev = bus_err;
    end
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
  endtask

  function automatic logic [38:0] outs();
    return {bus_start, bus_rw, bus_addr, bus_wdata, address, data_vga,
            AoD, wr_ack, scan_busy, frame_done, bus_err};
  endfunction

  // The requester drops wr_req the cycle after it sees wr_ack.
  task automatic tick();
    @(negedge clk);
    if (wr_ack) wr_req = 1'b0;
  endtask

  task automatic wait_frames(input int n, input string tag);
    int k;
    k = 0;
    while (frames < n && k < 1000) begin
      tick();
      k++;
    end
    chk(tag, frames, n);
  endtask

  task automatic wait_start(input logic [7:0] a, input logic rw, input string tag);
    int k;
    k = 0;
    do begin
      tick();
      k++;
    end while (!(bus_start && bus_rw == rw && bus_addr == a) && k < 1000);
    chk(tag, k < 1000, 1'b1);
  endtask

  task automatic ev_read(input logic [7:0] a, input logic p);
    ev.push_back('{1'b1, a, 8'h00, p});
  endtask

  task automatic ev_write(input logic [7:0] a, input logic [7:0] d);
    ev.push_back('{1'b0, a, d, 1'b0});
  endtask

  // Compare logged transactions/pushes from the given offsets against ev.
  task automatic check_seq(input string tag, input int tb, input int pb);
    int k;
    int np;
    k  = pb;
    np = 0;
    chk({tag, " txn_count"}, txn.size() - tb, ev.size());
    for (int i = 0; i < ev.size(); i++) begin
      if (tb + i < txn.size()) begin
        chk($sformatf("%s txn%0d", tag, i),
            {txn[tb+i].rw, txn[tb+i].addr, txn[tb+i].rw ? 8'h00 : txn[tb+i].wdata},
            {ev[i].rw, ev[i].addr, ev[i].wdata});
        if (ev[i].push) begin
          np++;
          if (k < pushes.size()) begin
            chk($sformatf("%s push%0d", tag, i), {pushes[k].addr, pushes[k].data},
                {ev[i].addr, ev[i].addr ^ 8'h5A});
            chk($sformatf("%s push_lat%0d", tag, i), pushes[k].cyc - txn[tb+i].cyc, 4);
          end
          k++;
        end
      end
    end
    chk({tag, " push_count"}, pushes.size() - pb, np);
  endtask

  task automatic ev_scan(input logic [7:0] skip, input int wr_after,
                         input logic [7:0] wa, input logic [7:0] wd);
    ev_write(8'hF0, 8'hF0);
    for (int i = 0; i < 11; i++) begin
      ev_read(scan_tbl[i], scan_tbl[i] != skip);
      if (i == wr_after) ev_write(wa, wd);
    end
  endtask

  initial begin
    int tb, pb, f, nt, np;
    scan_tbl  = '{8'h21, 8'h22, 8'h23, 8'h24, 8'h25, 8'h26, 8'h27, 8'h28,
                  8'h41, 8'h42, 8'h43};
    reset     = 1'b1;
    wr_req    = 1'b0;
    wr_addr   = 8'h00;
    wr_data   = 8'h00;
    spur      = 1'b0;
    drop_addr = 8'h00;

    // Reset values and immediate first scan.
    tick();
    tick();
    chk("reset_values", outs(), RST_VEC);
    reset = 1'b0;
    tick();
    chk("first_latch", {bus_start, bus_rw, bus_addr, bus_wdata, scan_busy},
        {1'b1, 1'b0, 8'hF0, 8'hF0, 1'b1});

    // Power-up scan.
    wait_frames(1, "scan1_frame");
    ev.delete();
    ev_scan(8'h00, -1, 8'h00, 8'h00);
    check_seq("scan1", 0, 0);
    chk("scan1_busy_clear", scan_busy, 1'b0);
    chk("scan1_read_gap", txn[2].cyc - txn[1].cyc, 6);

    // Mid-scan write raised during the 0x24 read.
    tb = txn.size();
    pb = pushes.size();
    wait_start(8'h24, 1'b1, "scan2_see_24");
    chk("refresh_gap", txn[tb].cyc - fd_q[0], 65);
    wr_addr = 8'h22;
    wr_data = 8'h59;
    wr_req  = 1'b1;
    wait_frames(2, "scan2_frame");
    ev.delete();
    ev_scan(8'h00, 3, 8'h22, 8'h59);
    check_seq("scan2", tb, pb);
    chk("scan2_acks", acks, 1);
    chk("scan2_wr_after_push24", txn[tb+5].cyc > pushes[pb+3].cyc, 1'b1);

    // Write arriving on the cycle the refresh falls due; 0x26 then times out.
    tb = txn.size();
    pb = pushes.size();
    f  = fd_q[1];
    while (cyc < f + 64) tick();
    drop_addr = 8'h26;
    wr_addr   = 8'h30;
    wr_data   = 8'hA5;
    wr_req    = 1'b1;
    wait_frames(3, "scan3_frame");
    ev.delete();
    ev_write(8'h30, 8'hA5);
    ev_scan(8'h26, -1, 8'h00, 8'h00);
    check_seq("scan3", tb, pb);
    chk("scan3_write_cycle", txn[tb].cyc, f + 65);
    chk("scan3_acks", acks, 2);
    chk("timeout_err_rise", err_rise, txn[tb+7].cyc + 33);
    chk("timeout_next_read", txn[tb+8].cyc - txn[tb+7].cyc, 34);
    chk("timeout_err_sticky", bus_err, 1'b1);
    drop_addr = 8'h00;

    // bus_err clears at the next latch; then reset lands in RD_WAIT.
    wait_start(8'hF0, 1'b0, "scan4_latch");
    chk("err_clear_at_latch", {txn[txn.size()-1].err, bus_err}, 2'b00);
    wait_start(8'h23, 1'b1, "scan4_see_23");
    tick();
    reset = 1'b1;
    tick();
    chk("midscan_reset_values", outs(), RST_VEC);
    reset = 1'b0;
    tb = txn.size();
    pb = pushes.size();

    // Restarted scan, with a spurious bus_done during the 0x25 PUSH.
    nt = 0;
    while (!(!AoD && address == 8'h25) && nt < 300) begin
      tick();
      nt++;
    end
    chk("scan5_see_push25", nt < 300, 1'b1);
    spur = 1'b1;
    tick();
    spur = 1'b0;
    wait_frames(4, "scan5_frame");
    ev.delete();
    ev_scan(8'h00, -1, 8'h00, 8'h00);
    check_seq("scan5", tb, pb);

    // Spurious bus_done in IDLE must not disturb anything.
    f = fd_q[3];
    for (int i = 0; i < 5; i++) tick();
    nt = txn.size();
    np = pushes.size();
    spur = 1'b1;
    tick();
    spur = 1'b0;
    for (int i = 0; i < 5; i++) tick();
    chk("idle_spur_txn", txn.size(), nt);
    chk("idle_spur_push", pushes.size(), np);
    wait_start(8'hF0, 1'b0, "scan6_latch");
    chk("idle_spur_gap", txn[txn.size()-1].cyc - f, 65);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/rtc_scan_controller.md
# rtc_scan_controller

Sequencer that periodically refreshes the time/date and timer register bank from the RTC chip and arbitrates user write requests (time setting) onto the same RTC bus. It issues a latch command, reads the 11 RTC registers (0x21–0x28, 0x41–0x43) through the RTC bus transceiver, and presents each result to the register bank with the address/AoD/data_vga capture convention. It sits between the edit/FSM logic, the RTC bus transceiver and the display register bank.

## Interface
- REFRESH_CYCLES, 100000: idle cycles between the end of one scan and the start of the next.
- TIMEOUT_CYCLES, 1024: maximum cycles to wait for bus_done.
- LATCH_ADDR, 8'hF0: command address written before each scan; its data is also 8'hF0.

- clk  in  1  system clock.
- reset  in  1  synchronous, active-high.
- wr_req  in  1  user write request, level, held until wr_ack.
- wr_addr  in  8  user write address, stable while wr_req.
- wr_data  in  8  user write data, stable while wr_req.
- wr_ack  out  1  one-cycle pulse: user write completed.
- bus_start  out  1  one-cycle pulse: start transceiver transaction.
- bus_rw  out  1  1 = read, 0 = write.
- bus_addr  out  8  transaction address.
- bus_wdata  out  8  write data.
- bus_done  in  1  one-cycle pulse from transceiver: transaction complete.
- bus_rdata  in  8  read data, valid with bus_done.
- address  out  8  register-bank address.
- data_vga  out  8  register-bank data.
- AoD  out  1  0 = data valid; the bank captures on the clk edge where AoD = 0.
- scan_busy  out  1  high from LATCH through the last PUSH.
- frame_done  out  1  one-cycle pulse after the PUSH of 0x43.
- bus_err  out  1  sticky timeout flag; cleared at the next scan start.

## Operation
- Reset values:
  - bus_start = 0, bus_rw = 1, bus_addr = 0, bus_wdata = 0.
  - address = 0, data_vga = 0, AoD = 1.
  - wr_ack = 0, scan_busy = 0, frame_done = 0, bus_err = 0.
  - Scan index = 0. Refresh counter preloaded so the first scan starts the first cycle after reset deasserts.
- Scan order, index 0..10: 0x21, 0x22, 0x23, 0x24, 0x25, 0x26, 0x27, 0x28, 0x41, 0x42, 0x43.
- States:
  - IDLE: the refresh counter increments. If wr_req → WR (this takes priority over a due refresh). Else if the counter reached REFRESH_CYCLES-1 → LATCH (clears the counter and bus_err).
  - LATCH: bus_start pulse, bus_rw = 0, bus_addr = bus_wdata = LATCH_ADDR → LATCH_WAIT.
  - LATCH_WAIT: on bus_done → RD.
  - RD: bus_start pulse, bus_rw = 1, bus_addr = table[idx] → RD_WAIT.
  - RD_WAIT: on bus_done, register bus_rdata → PUSH.
  - PUSH: for exactly one cycle, address = table[idx], data_vga = registered data, AoD = 0 → NEXT.
  - NEXT: if idx == 10, pulse frame_done, idx ← 0 → IDLE. Else idx++; then wr_req → WR, else → RD.
  - WR: bus_start pulse, bus_rw = 0, bus_addr = wr_addr, bus_wdata = wr_data → WR_WAIT.
  - WR_WAIT: on bus_done, pulse wr_ack; return to IDLE if no scan was in progress, else to RD at the current idx.
- A user write therefore interleaves only between registers. A scan is never restarted by a write.
- Outside PUSH: address = 8'h00 and AoD = 1. 0x00 matches no bank register.
- bus_addr, bus_rw and bus_wdata stay stable from bus_start until bus_done.
- bus_done is sampled only in *_WAIT states. It is ignored elsewhere, including a pulse in the same cycle as bus_start.
- Timeout: a per-transaction counter runs in each *_WAIT state. When it reaches TIMEOUT_CYCLES without bus_done, set bus_err and abandon the transaction:
  - read: skip PUSH, go to NEXT;
  - latch: proceed to RD;
  - write: still pulse wr_ack so the requester is released.
- Reset mid-operation: the next cycle has all reset values. The transaction in flight is abandoned; the transceiver resets on the same signal.

## Timing
- Read latency: bus_done at cycle t → AoD low at t+1 → next bus_start at t+3 (NEXT at t+2).
- wr_ack is asserted the cycle after bus_done. The requester deasserts wr_req the cycle after wr_ack. wr_req high during wr_ack's cycle is not re-serviced.
- The refresh counter is held during a scan and during writes.

## Structure
- Package rtc_pkg holds:
  - the 11-entry scan address table and the constants 0x21/0x41/0xF0;
  - the state enum;
  - SCAN_LEN = 11.
- One sub-module, rtc_timer_cnt: a loadable terminal-count counter. Instantiate it twice, once for refresh and once for timeout.

## Test plan
- Power-up scan: REFRESH_CYCLES=64; transceiver model returns rdata = addr^8'h5A after 3 cycles. Expected: write F0/F0, then 11 reads in table order; each read gives one AoD=0 cycle with data_vga = addr^5A (e.g. 0x21→0x7B); one frame_done; the next scan starts 64 cycles later.
- Mid-scan write: wr_req (0x22, 0x59) raised during the 0x24 read. Expected: the 0x24 PUSH occurs, then a write with bus_rw=0, addr 0x22, data 0x59; one wr_ack; the scan resumes with 0x25.
- Write versus due refresh in IDLE, same cycle. Expected: the write is issued first, then LATCH.
- Timeout: no bus_done for 0x26, TIMEOUT_CYCLES=32. Expected: bus_err=1 after 32 cycles; no AoD for 0x26; the 0x27 read follows; bus_err=0 at the next LATCH.
- Reset asserted in RD_WAIT. Expected: the next cycle matches the reset values exactly; the next scan restarts at LATCH with idx 0.
- Spurious bus_done in IDLE and in PUSH. Expected: no state change, no extra AoD pulse.
